pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Fetch stage directly upstream of next_pc_mux.
- Holds the architectural PC, produces pc_plus4 for the mux, and fetches the instruction at PC over a valid/ready instruction-memory interface.
- Presents the instruction to decode and accepts pc_next from next_pc_mux when the core consumes the current instruction.
- One outstanding request at a time; sticky fault on a misaligned pc_next.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instr value while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_next  in  32  next PC from next_pc_mux.
- instr_ready  in  1  core has consumed the presented instruction; load pc_next.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  memory response valid.
- imem_rsp_data  in  32  fetched instruction word.
- imem_req_valid  out  1  request valid.
- imem_addr  out  32  request address (= pc).
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, combinational, to next_pc_mux.
- instr  out  32  held instruction.
- instr_valid  out  1  instr corresponds to pc.
- fetch_fault  out  1  sticky misaligned-target fault.
- fetch_count  out  32  number of instructions consumed.

Behaviour:
- Reset (async assert, rst_n=0) values:
  - state=IDLE, pc=RESET_VECTOR, instr=NOP_INSTR.
  - instr_valid=0, imem_req_valid=0, fetch_fault=0, fetch_count=0.
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: next cycle goes to REQ unconditionally. This gives one dead cycle after reset release.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - Request is accepted when imem_req_valid & imem_req_ready at a clock edge; then go to WAIT.
  - Otherwise stay in REQ with addr stable. Never drop valid before acceptance.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: instr<=imem_rsp_data, instr_valid<=1, go to HOLD.
  - Same-cycle response to the request is not possible; the earliest response is the cycle after acceptance.
- HOLD:
  - instr_valid=1; instr and pc are stable.
  - On instr_ready:
    - pc<=pc_next, fetch_count<=fetch_count+1 (wraps modulo 2^32), instr_valid<=0, instr<=NOP_INSTR.
    - If pc_next[1:0]!=2'b00, go to FAULT; else go to REQ.
- FAULT:
  - fetch_fault=1, imem_req_valid=0, instr_valid=0.
  - pc holds the faulting pc_next value.
  - Exit only via reset.
- Latency:
  - Best case: request accepted in cycle N, response in N+1, instr_valid high from N+2.
  - After instr_ready in cycle M, the next request is issued in cycle M+1.
- Ignored events:
  - imem_rsp_valid outside WAIT (stale or spurious).
  - instr_ready outside HOLD.
  - pc_next outside the HOLD&instr_ready cycle.
- pc_plus4 = pc + 32'd4, 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000). Computed in every state, including FAULT.
- Reset mid-operation (any state): immediate return to reset values. A response arriving after release is dropped, since the state is IDLE/REQ.
- imem_addr always equals pc, including when imem_req_valid=0.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD, FAULT}
  - localparam NOP_INSTR
  - localparam PC_INCR = 32'd4
  - default RESET_VECTOR
- Optional sub-module pc_reg: 32-bit register with async active-low reset to RESET_VECTOR and a load enable. The FSM and imem handshake stay in pc_fetch_unit.

Test Plan:
- Reset release, imem_req_ready=1, response 1 cycle later with 32'h0010_0093 → imem_addr=0x0 in the request cycle; instr_valid=1, instr=0x00100093, pc_plus4=0x4 two cycles after acceptance.
- imem_req_ready held 0 for 3 cycles → imem_req_valid stays 1 and imem_addr stays constant; WAIT is entered only on the ready cycle.
- In HOLD, pc_next=0x40, instr_ready=1 → next cycle pc=0x40, fetch_count=1, next request addr=0x40. instr_ready held 0 keeps instr and pc unchanged.
- pc_next=0x42 with instr_ready → FAULT: fetch_fault=1, pc=0x42, no further requests; rsp_valid pulses are ignored; only rst_n clears it.
- Spurious imem_rsp_valid in REQ and HOLD, with data 0xDEADBEEF → instr unchanged.
- rst_n asserted while in WAIT, response arriving the cycle after release → response dropped; pc=RESET_VECTOR; fresh request to RESET_VECTOR; fetch_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// No logic here; imported by pc_fetch_unit and its PC register.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] PC_INCR      = 32'd4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // Word-aligned targets only; anything else is a sticky fetch fault.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Architectural PC register: loads d when load is set, resets to RESET_VECTOR.
// Zero latency to q after the loading edge; no backpressure.
module pc_reg #(
  parameter logic [31:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VECTOR;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: one outstanding imem request at PC, holds the word for decode; accept->instr_valid is 2 cycles best case.
// Request valid is held until imem_req_ready; the held instruction stays until instr_ready, then pc_next is loaded.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR    = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next,
  input  logic        instr_ready,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        imem_req_valid,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  import fetch_pkg::*;

  fetch_state_t state;
  logic         pc_load;
  logic [31:0]  pc_q;

  // pc_next is only sampled on the cycle decode consumes the held word.
  assign pc_load = (state == HOLD) && instr_ready;

  pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .load (pc_load),
    .d    (pc_next),
    .q    (pc_q)
  );

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + PC_INCR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      instr          <= NOP_INSTR;
      instr_valid    <= 1'b0;
      imem_req_valid <= 1'b0;
      fetch_fault    <= 1'b0;
      fetch_count    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state          <= REQ;
          imem_req_valid <= 1'b1;
        end
        REQ: begin
          if (imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state       <= HOLD;
            instr       <= imem_rsp_data;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            fetch_count <= fetch_count + 32'd1;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            if (is_misaligned(pc_next[1:0])) begin
              state       <= FAULT;
              fetch_fault <= 1'b1;
            end else begin
              state          <= REQ;
              imem_req_valid <= 1'b1;
            end
          end
        end
        FAULT: begin
          // Terminal until reset; PC keeps the offending target for debug.
          state <= FAULT;
        end
        default: begin
          state          <= IDLE;
          imem_req_valid <= 1'b0;
          instr_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized transaction model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_next;
  logic        instr_ready;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  // Reference model state: what the fetch stage should be holding.
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic [31:0] exp_instr;

  pc_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_next       (pc_next),
    .instr_ready   (instr_ready),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_req_valid(imem_req_valid),
    .imem_addr     (imem_addr),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .fetch_fault   (fetch_fault),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req_valid(input string tag);
    int n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL %s_req_timeout: got %b want 1", tag, imem_req_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; pc_next = 32'h0; instr_ready = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    #2;
    rst_n = 1'b0;
    tick(); tick();
    total++; if (pc !== RV) begin bad++; $display("FAIL rst_pc: got %h want %h", pc, RV); end
    total++; if (imem_addr !== RV) begin bad++; $display("FAIL rst_addr: got %h want %h", imem_addr, RV); end
    total++; if (instr !== NOP) begin bad++; $display("FAIL rst_instr: got %h want %h", instr, NOP); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fetch_count); end
    total++; if (pc_plus4 !== RV + 32'd4) begin bad++; $display("FAIL rst_pc_plus4: got %h want %h", pc_plus4, RV + 32'd4); end
    rst_n = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL idle_dead_cycle: got %b want 0", imem_req_valid); end
    tick();
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
  endtask

  task automatic test_first_fetch();
    total++; if (imem_addr !== RV) begin bad++; $display("FAIL first_addr: got %h want %h", imem_addr, RV); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL first_wait_req: got %b want 0", imem_req_valid); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL first_wait_valid: got %b want 0", instr_valid); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
    tick();
    imem_rsp_valid = 1'b0;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL first_instr_valid: got %b want 1", instr_valid); end
    total++; if (instr !== 32'h0010_0093) begin bad++; $display("FAIL first_instr: got %h want 00100093", instr); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL first_pc_plus4: got %h want 4", pc_plus4); end
    exp_pc = RV; exp_cnt = 0; exp_instr = 32'h0010_0093;
  endtask

  task automatic test_hold_and_advance();
    for (int i = 0; i < 3; i++) begin
      pc_next = $urandom(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      tick();
      total++; if (instr !== exp_instr) begin bad++; $display("FAIL hold_instr: got %h want %h", instr, exp_instr); end
      total++; if (pc !== exp_pc) begin bad++; $display("FAIL hold_pc: got %h want %h", pc, exp_pc); end
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL hold_valid: got %b want 1", instr_valid); end
    end
    imem_rsp_valid = 1'b0;
    pc_next = 32'h40; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0; pc_next = 32'h0BAD_0001;
    exp_pc = 32'h40; exp_cnt++; exp_instr = NOP;
    total++; if (pc !== exp_pc) begin bad++; $display("FAIL adv_pc: got %h want %h", pc, exp_pc); end
    total++; if (fetch_count !== exp_cnt) begin bad++; $display("FAIL adv_count: got %0d want %0d", fetch_count, exp_cnt); end
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL adv_req_valid: got %b want 1", imem_req_valid); end
    total++; if (imem_addr !== exp_pc) begin bad++; $display("FAIL adv_addr: got %h want %h", imem_addr, exp_pc); end
    total++; if (instr !== NOP || instr_valid !== 1'b0) begin bad++; $display("FAIL adv_instr: got %h/%b want %h/0", instr, instr_valid, NOP); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      tick();
      total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL bp_req_valid: got %b want 1", imem_req_valid); end
      total++; if (imem_addr !== exp_pc) begin bad++; $display("FAIL bp_addr: got %h want %h", imem_addr, exp_pc); end
      total++; if (instr !== NOP) begin bad++; $display("FAIL bp_spurious_instr: got %h want %h", instr, NOP); end
    end
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_wait_entry: got %b want 0", imem_req_valid); end
    d = $urandom();
    imem_rsp_valid = 1'b1; imem_rsp_data = d;
    tick();
    imem_rsp_valid = 1'b0;
    exp_instr = d;
    total++; if (instr !== exp_instr || instr_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp: got %h/%b want %h/1", instr, instr_valid, exp_instr); end
  endtask

  task automatic test_random();
    logic [31:0] r, nxt, d;
    int n;
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        imem_rsp_valid = $urandom_range(0, 1); imem_rsp_data = $urandom(); pc_next = $urandom();
        tick();
        total++; if (instr !== exp_instr) begin bad++; $display("FAIL rnd_hold_instr: got %h want %h", instr, exp_instr); end
      end
      imem_rsp_valid = 1'b0;
      r = $urandom();
      nxt = (t == 5) ? 32'hFFFF_FFFC : {r[31:2], 2'b00};
      pc_next = nxt; instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0; pc_next = $urandom();
      exp_pc = nxt; exp_cnt++;
      total++; if (pc !== exp_pc) begin bad++; $display("FAIL rnd_pc: got %h want %h", pc, exp_pc); end
      total++; if (fetch_count !== exp_cnt) begin bad++; $display("FAIL rnd_count: got %0d want %0d", fetch_count, exp_cnt); end
      total++; if (pc_plus4 !== exp_pc + 32'd4) begin bad++; $display("FAIL rnd_pc_plus4: got %h want %h", pc_plus4, exp_pc + 32'd4); end
      total++; if (instr !== NOP || instr_valid !== 1'b0) begin bad++; $display("FAIL rnd_consumed: got %h/%b want %h/0", instr, instr_valid, NOP); end
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        imem_rsp_valid = $urandom_range(0, 1); imem_rsp_data = $urandom();
        tick();
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc) begin bad++; $display("FAIL rnd_stall: got %b/%h want 1/%h", imem_req_valid, imem_addr, exp_pc); end
      end
      imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rnd_accept: got %b want 0", imem_req_valid); end
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rnd_wait_valid: got %b want 0", instr_valid); end
      end
      d = $urandom();
      imem_rsp_valid = 1'b1; imem_rsp_data = d;
      tick();
      imem_rsp_valid = 1'b0;
      exp_instr = d;
      total++; if (instr !== exp_instr || instr_valid !== 1'b1) begin bad++; $display("FAIL rnd_rsp: got %h/%b want %h/1", instr, instr_valid, exp_instr); end
    end
  endtask

  task automatic test_reset_in_wait();
    pc_next = 32'h80; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    total++; if (fetch_count !== exp_cnt + 32'd1) begin bad++; $display("FAIL riw_precount: got %0d want %0d", fetch_count, exp_cnt + 32'd1); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (pc !== RV || fetch_count !== 32'd0) begin bad++; $display("FAIL riw_async: got %h/%0d want %h/0", pc, fetch_count, RV); end
    tick();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick(); tick();
    imem_rsp_valid = 1'b0;
    total++; if (instr !== NOP || instr_valid !== 1'b0) begin bad++; $display("FAIL riw_dropped: got %h/%b want %h/0", instr, instr_valid, NOP); end
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== RV) begin bad++; $display("FAIL riw_fresh_req: got %b/%h want 1/%h", imem_req_valid, imem_addr, RV); end
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL riw_count: got %0d want 0", fetch_count); end
    exp_pc = RV; exp_cnt = 0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0113;
    tick();
    imem_rsp_valid = 1'b0;
    exp_instr = 32'h0050_0113;
    total++; if (instr !== exp_instr || instr_valid !== 1'b1) begin bad++; $display("FAIL riw_refetch: got %h/%b want %h/1", instr, instr_valid, exp_instr); end
  endtask

  task automatic test_fault();
    pc_next = 32'h42; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    exp_cnt++;
    total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL flt_set: got %b want 1", fetch_fault); end
    total++; if (pc !== 32'h42) begin bad++; $display("FAIL flt_pc: got %h want 42", pc); end
    total++; if (pc_plus4 !== 32'h46) begin bad++; $display("FAIL flt_pc_plus4: got %h want 46", pc_plus4); end
    total++; if (fetch_count !== exp_cnt) begin bad++; $display("FAIL flt_count: got %0d want %0d", fetch_count, exp_cnt); end
    for (int i = 0; i < 5; i++) begin
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      instr_ready = 1'b1; pc_next = 32'h100;
      tick();
      total++; if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL flt_sticky: got fault=%b req=%b vld=%b want 1/0/0", fetch_fault, imem_req_valid, instr_valid); end
      total++; if (pc !== 32'h42 || instr !== NOP) begin bad++; $display("FAIL flt_hold: got %h/%h want 42/%h", pc, instr, NOP); end
    end
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; instr_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (fetch_fault !== 1'b0 || pc !== RV || fetch_count !== 32'd0) begin bad++; $display("FAIL flt_clear: got %b/%h/%0d want 0/%h/0", fetch_fault, pc, fetch_count, RV); end
    tick();
    rst_n = 1'b1;
    tick();
    wait_req_valid("flt_restart");
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold_and_advance();
    test_backpressure();
    test_random();
    test_reset_in_wait();
    test_fault();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
